// File: rtl/priority_req_gen_8ch.sv
// Requester side of an 8-input fixed-priority arbiter: per-channel saturating
// pending counts drive req, grants retire work, plus starvation and grant-bus checks.

module priority_req_gen_lane #(
    parameter int CNT_W        = 4,
    parameter int STARVE_W     = 8,
    parameter int STARVE_LIMIT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic post,
    input  logic grant,
    output logic req,
    output logic done,
    output logic full,
    output logic overflow,
    output logic starve
);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [STARVE_W-1:0] WAIT_MAX = '1;
    localparam logic [STARVE_W-1:0] LIMIT    = STARVE_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]    cnt;
    logic [STARVE_W-1:0] wait_q, wait_nxt;
    logic                accept;

    // req comes only from the registered count, so grant never loops back into it
    assign req    = (cnt != '0);
    assign full   = (cnt == CNT_MAX);
    assign accept = grant & req;

    always_comb begin
        wait_nxt = wait_q;
        if (!req || accept)
            wait_nxt = '0;
        else if (wait_q != WAIT_MAX)
            wait_nxt = wait_q + STARVE_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            wait_q   <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            starve   <= 1'b0;
        end else begin
            // post and accept together cancel, so a post at max is kept when granted
            if (post && !accept) begin
                if (full)
                    overflow <= 1'b1;
                else
                    cnt <= cnt + CNT_W'(1);
            end else if (accept && !post) begin
                cnt <= cnt - CNT_W'(1);
            end
            done   <= accept;
            wait_q <= wait_nxt;
            starve <= (wait_nxt >= LIMIT);
        end
    end
endmodule

module priority_req_gen_8ch #(
    parameter int CNT_W        = 4,
    parameter int STARVE_W     = 8,
    parameter int STARVE_LIMIT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] post,
    input  logic [7:0] grant,
    output logic [7:0] req,
    output logic [7:0] done,
    output logic [7:0] pending_full,
    output logic [7:0] overflow,
    output logic [7:0] starve,
    output logic       grant_err
);
    logic multi_grant, spurious_grant, missing_grant;

    priority_req_gen_lane #(
        .CNT_W       (CNT_W),
        .STARVE_W    (STARVE_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_lane [7:0] (
        .clk     (clk),
        .rst     (rst),
        .post    (post),
        .grant   (grant),
        .req     (req),
        .done    (done),
        .full    (pending_full),
        .overflow(overflow),
        .starve  (starve)
    );

    // x & (x-1) is nonzero exactly when more than one bit is set
    assign multi_grant    = ((grant & (grant - 8'd1)) != 8'd0);
    assign spurious_grant = ((grant & ~req) != 8'd0);
    assign missing_grant  = (grant == 8'd0) && (req != 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            grant_err <= 1'b0;
        else if (multi_grant || spurious_grant || missing_grant)
            grant_err <= 1'b1;
    end
endmodule

// File: tb/tb_priority_req_gen_8ch.sv
// Bench for priority_req_gen_8ch: integer-count reference model with a
// fixed-priority arbiter in the loop, plus directed and random scenarios.

module tb_priority_req_gen_8ch;
    localparam int LIMIT = 200;
    localparam int MAXC  = 15;
    localparam int WMAX  = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] post = 8'h00;
    logic [7:0] grant = 8'h00;
    logic [7:0] req, done, pending_full, overflow, starve;
    logic       grant_err;

    int errors = 0;
    int checks = 0;

    int         m_cnt[8];
    int         m_wait[8];
    logic [7:0] m_done, m_ovf, m_starve;
    logic       m_gerr;

    priority_req_gen_8ch #(.CNT_W(4), .STARVE_W(8), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .post(post), .grant(grant), .req(req), .done(done),
        .pending_full(pending_full), .overflow(overflow), .starve(starve),
        .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mreq();
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) r[i] = (m_cnt[i] > 0);
        return r;
    endfunction

    function automatic logic [7:0] mfull();
        logic [7:0] f = 8'h00;
        for (int i = 0; i < 8; i++) f[i] = (m_cnt[i] == MAXC);
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_cnt[i]  = 0;
            m_wait[i] = 0;
        end
        m_done = 8'h00; m_ovf = 8'h00; m_starve = 8'h00; m_gerr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; post = 8'h00; grant = 8'h00;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // One clock: mode 0 = priority arbiter on model req, 1 = no grant, 2 = forced grant fg
    task automatic step(input logic [7:0] p, input int mode, input logic [7:0] fg);
        logic [7:0] r, g;
        logic acc;
        r = mreq();
        g = 8'h00;
        if (mode == 0) begin
            for (int i = 0; i < 8; i++) if (r[i]) g = 8'h01 << i;
        end else if (mode == 2) begin
            g = fg;
        end
        post = p; grant = g;
        if ($countones(g) > 1 || (g & ~r) != 8'h00 || (g == 8'h00 && r != 8'h00)) m_gerr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            acc = g[i] && r[i];
            if (p[i] && !acc) begin
                if (m_cnt[i] == MAXC) m_ovf[i] = 1'b1;
                else m_cnt[i] = m_cnt[i] + 1;
            end else if (acc && !p[i]) begin
                m_cnt[i] = m_cnt[i] - 1;
            end
            m_done[i] = acc;
            if (!r[i] || acc) m_wait[i] = 0;
            else if (m_wait[i] < WMAX) m_wait[i] = m_wait[i] + 1;
            m_starve[i] = (m_wait[i] >= LIMIT);
        end
        @(posedge clk); @(negedge clk);
        post = 8'h00; grant = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req, done, pending_full, overflow, starve, grant_err} !== 41'd0) begin
            errors++; $display("FAIL reset_state: got req=%h done=%h full=%h ovf=%h starve=%h gerr=%b want all 0",
                               req, done, pending_full, overflow, starve, grant_err);
        end
        for (int k = 0; k < 5; k++) step(8'h08, 1, 8'h00);
        checks++;
        if (req !== 8'h08 || grant_err !== 1'b1) begin
            errors++; $display("FAIL reset_prefill: got req=%h gerr=%b want 08 1", req, grant_err);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({req, done, pending_full, overflow, starve, grant_err} !== 41'd0) begin
            errors++; $display("FAIL reset_async: got req=%h done=%h ovf=%h starve=%h gerr=%b want all 0",
                               req, done, overflow, starve, grant_err);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        step(8'h00, 0, 8'h00);
        checks++;
        if (req !== 8'h00 || done !== 8'h00) begin
            errors++; $display("FAIL reset_release: got req=%h done=%h want 00 00", req, done);
        end
    endtask

    task automatic test_single();
        do_reset();
        step(8'h04, 0, 8'h00);
        checks++;
        if (req !== 8'h04 || done !== 8'h00) begin
            errors++; $display("FAIL single_req: got req=%h done=%h want 04 00", req, done);
        end
        step(8'h00, 0, 8'h00);
        checks++;
        if (done !== 8'h04 || req !== 8'h00) begin
            errors++; $display("FAIL single_done: got done=%h req=%h want 04 00", done, req);
        end
        step(8'h00, 0, 8'h00);
        checks++;
        if (done !== 8'h00 || grant_err !== 1'b0) begin
            errors++; $display("FAIL single_after: got done=%h gerr=%b want 00 0", done, grant_err);
        end
    endtask

    task automatic test_priority();
        logic [7:0] want;
        do_reset();
        step(8'hff, 0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            step(8'h00, 0, 8'h00);
            want = 8'h80 >> k;
            checks++;
            if (done !== want || req !== mreq()) begin
                errors++; $display("FAIL priority_order[%0d]: got done=%h req=%h want %h %h", k, done, req, want, mreq());
            end
        end
        checks++;
        if (req !== 8'h00 || grant_err !== 1'b0) begin
            errors++; $display("FAIL priority_end: got req=%h gerr=%b want 00 0", req, grant_err);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 15; k++) step(8'h01, 1, 8'h00);
        checks++;
        if (pending_full !== 8'h01 || overflow !== 8'h00 || req !== 8'h01) begin
            errors++; $display("FAIL sat_fill: got full=%h ovf=%h req=%h want 01 00 01", pending_full, overflow, req);
        end
        step(8'h01, 0, 8'h00);
        checks++;
        if (pending_full !== 8'h01 || overflow !== 8'h00 || done !== 8'h01) begin
            errors++; $display("FAIL sat_post_grant: got full=%h ovf=%h done=%h want 01 00 01", pending_full, overflow, done);
        end
        step(8'h01, 1, 8'h00);
        checks++;
        if (overflow !== 8'h01 || pending_full !== 8'h01) begin
            errors++; $display("FAIL sat_drop: got ovf=%h full=%h want 01 01", overflow, pending_full);
        end
        for (int k = 0; k < 15; k++) begin
            step(8'h00, 0, 8'h00);
            checks++;
            if (done !== 8'h01 || req !== mreq() || pending_full !== 8'h00) begin
                errors++; $display("FAIL sat_drain[%0d]: got done=%h req=%h full=%h want 01 %h 00", k, done, req, pending_full, mreq());
            end
        end
        checks++;
        if (req !== 8'h00 || overflow !== 8'h01) begin
            errors++; $display("FAIL sat_empty: got req=%h ovf=%h want 00 01", req, overflow);
        end
    endtask

    task automatic test_starve();
        do_reset();
        step(8'h81, 0, 8'h00);
        for (int k = 1; k <= 200; k++) begin
            step(8'h80, 0, 8'h00);
            checks++;
            if (starve !== m_starve || done !== 8'h80) begin
                errors++; $display("FAIL starve_wait[%0d]: got starve=%h done=%h want %h 80", k, starve, done, m_starve);
            end
        end
        checks++;
        if (starve !== 8'h01) begin
            errors++; $display("FAIL starve_rise: got starve=%h want 01", starve);
        end
        step(8'h00, 0, 8'h00);
        checks++;
        if (starve !== 8'h01 || done !== 8'h80) begin
            errors++; $display("FAIL starve_hold: got starve=%h done=%h want 01 80", starve, done);
        end
        step(8'h00, 0, 8'h00);
        checks++;
        if (starve !== 8'h00 || done !== 8'h01 || req !== 8'h00) begin
            errors++; $display("FAIL starve_clear: got starve=%h done=%h req=%h want 00 01 00", starve, done, req);
        end
    endtask

    task automatic test_violation();
        do_reset();
        step(8'h01, 0, 8'h00);
        step(8'h00, 2, 8'h03);
        checks++;
        if (grant_err !== 1'b1 || done !== 8'h01 || req !== 8'h00) begin
            errors++; $display("FAIL viol_multi: got gerr=%b done=%h req=%h want 1 01 00", grant_err, done, req);
        end
        for (int k = 0; k < 3; k++) step(8'h00, 0, 8'h00);
        checks++;
        if (grant_err !== 1'b1 || req !== 8'h00) begin
            errors++; $display("FAIL viol_sticky: got gerr=%b req=%h want 1 00", grant_err, req);
        end
        do_reset();
        step(8'h00, 2, 8'h10);
        checks++;
        if (grant_err !== 1'b1 || req !== 8'h00 || done !== 8'h00) begin
            errors++; $display("FAIL viol_spurious: got gerr=%b req=%h done=%h want 1 00 00", grant_err, req, done);
        end
    endtask

    task automatic test_random();
        logic [7:0] p, fg;
        int mode;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            p    = 8'($urandom) & 8'($urandom);
            fg   = 8'($urandom);
            mode = ($urandom_range(0, 9) == 0) ? 2 : 0;
            step(p, mode, fg);
            checks++;
            if (req !== mreq() || done !== m_done || pending_full !== mfull() ||
                overflow !== m_ovf || starve !== m_starve || grant_err !== m_gerr) begin
                errors++;
                $display("FAIL random[%0d]: got req=%h done=%h full=%h ovf=%h starve=%h gerr=%b want %h %h %h %h %h %b",
                         k, req, done, pending_full, overflow, starve, grant_err,
                         mreq(), m_done, mfull(), m_ovf, m_starve, m_gerr);
            end
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        test_reset();
        test_single();
        test_priority();
        test_saturation();
        test_starve();
        test_violation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/priority_req_gen_8ch.md
Name: priority_req_gen_8ch

Overview:
Requester-side companion to the team's 8-input fixed-priority arbiter (bit 7 highest).
- Accepts per-channel work pulses from 8 clients and keeps a saturating pending count per channel.
- Drives the registered req[7:0] vector into the arbiter and consumes the one-hot grant[7:0] it returns.
- Retires one pending item per grant, reports per-channel completion, flags starvation of low-priority channels, and flags protocol violations on the grant bus.

Parameters:
CNT_W, 4, width of each per-channel pending counter; max pending = 2^CNT_W-1
STARVE_W, 8, width of each per-channel wait counter
STARVE_LIMIT, 200, wait cycles with req high and no grant before starve[i] asserts (must be < 2^STARVE_W)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
post  input  8  post[i]=1 for one cycle enqueues one work item on channel i
grant  input  8  one-hot grant from the arbiter, combinational from req
req  output  8  req[i]=1 while channel i has pending work (driven from registered count)
done  output  8  done[i] pulses 1 cycle after channel i is granted
pending_full  output  8  pending_full[i]=1 while count[i] is at maximum
overflow  output  8  sticky: a post was dropped because count[i] was at maximum
starve  output  8  starve[i]=1 once channel i has waited STARVE_LIMIT cycles; clears on grant
grant_err  output  1  sticky: illegal grant pattern observed

Behaviour:
- Reset:
  - Asserting rst clears, at any time and without waiting for a clock edge: all counts, wait counters and flags.
  - Outputs go to req=0, done=0, pending_full=0, overflow=0, starve=0, grant_err=0.
  - A burst in progress is abandoned; no done is issued for it.
- Request output:
  - req[i] = (count[i] != 0). The value depends only on registered state, so no combinational path exists from grant to req.
  - A post in cycle N raises req[i] in cycle N+1.
- Accept:
  - accept[i] = grant[i] & req[i].
  - On accept[i], count[i] decrements at the next edge and done[i]=1 for exactly the following cycle.
- Count update per channel each edge:
  - post only: +1.
  - accept only: -1.
  - post and accept in the same cycle: unchanged.
  - Neither: unchanged.
- Saturation:
  - A post when count[i] is at maximum and there is no accept is dropped, count[i] holds, and overflow[i] sets (sticky until rst).
  - A post at maximum coinciding with an accept is not dropped (net unchanged).
  - pending_full[i] = (count[i] == max).
- Last item: when count[i] goes 1->0 on accept, req[i] drops the next cycle. The arbiter then moves to the next channel, with no gap cycle required.
- Starvation:
  - wait[i] increments each cycle req[i]=1 and grant[i]=0, saturating at max.
  - wait[i] clears on accept[i] or when req[i]=0.
  - starve[i] is registered (wait[i] >= STARVE_LIMIT) and clears the cycle after accept.
- Grant checking (grant_err sets, sticky until rst):
  - More than one grant bit is high, or
  - grant[i]=1 while req[i]=0, or
  - grant is all-zero while req is nonzero.
- In every grant_err case, no decrement occurs for non-requesting channels. If multiple granted channels are requesting, each requesting granted channel still decrements; this is error tolerance only, not legal operation.
- No FSM beyond the per-channel count/wait registers. Total state: 8×(CNT_W + STARVE_W) bits plus flags.

Test Plan:
- Reset check: assert rst mid-cycle with count[3]=5 -> req, done, starve, overflow and grant_err all 0 immediately; after release, req=0 until the next post.
- Single channel: pulse post[2] at cycle 0; bench arbiter grants -> req[2]=1 at cycle 1, grant at cycle 1, done[2]=1 at cycle 2, req[2]=0 at cycle 2.
- Priority order: post all 8 channels in one cycle with a priority-arbiter model in the loop -> done pulses in order 7,6,...,0 on consecutive cycles; req ends at 0 after 8 grants.
- Saturation: 16 posts to channel 0 with no grant -> count 15, pending_full[0]=1, overflow[0]=1; a post coinciding with a grant at count 15 -> count stays 15, no additional drop.
- Starvation: hold channel 7 busy with repeated posts while channel 0 has 1 pending, STARVE_LIMIT=200 -> starve[0] rises after 200 waiting cycles; stop channel 7 -> channel 0 granted, starve[0] clears the next cycle.
- Protocol violation: drive grant=8'b0000_0011 with req=8'b0000_0001 -> grant_err=1 and stays 1; count[1] is unchanged.
